// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch stage and the decoder:
// fetch FSM encoding, opcode constants and PC alignment helper.
package inst_fetch_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  localparam logic [5:0]  OP_RTYPE   = 6'h00;
  localparam logic [5:0]  OP_J       = 6'h02;
  localparam logic [5:0]  OP_JAL     = 6'h03;
  localparam logic [31:0] WORD_BYTES = 32'd4;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Bundle of the fetch stage's memory, redirect and decode-side signals.
// Handshakes: imem_req is a one-cycle strobe with at most one read
// outstanding, answered by a one-cycle imem_rvalid; an instruction moves to
// decode on a cycle where inst_valid and id_ready are both high, and the
// held word/address stay stable while inst_valid=1 and id_ready=0.
interface inst_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        id_ready;
  logic [31:0] instruction;
  logic [31:0] p_count;

  modport master (
    output imem_req, imem_addr, inst_valid, instruction, p_count,
    input  imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, instruction, p_count,
    output imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/inst_fetch_pc_gen.sv
// Combinational next-PC select: redirect target, predecoded jump target or
// pc+4. Jump predecode is built only with FETCH_PREDECODE_JUMP_EN defined.
module fetch_pc_gen
  import inst_fetch_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] pc_next_o
);

  logic [31:0] pc_plus4;
  logic [31:0] seq_pc;

  // Plain 32-bit add: 0xFFFF_FFFC wraps to 0 by design.
  assign pc_plus4 = pc_i + WORD_BYTES;

`ifdef FETCH_PREDECODE_JUMP_EN
  logic is_jump;
  assign is_jump = (rdata_i[31:26] == OP_J) || (rdata_i[31:26] == OP_JAL);
  assign seq_pc  = is_jump ? {pc_plus4[31:28], rdata_i[25:0], 2'b00} : pc_plus4;
`else
  logic unused_rdata;
  assign unused_rdata = ^rdata_i;
  assign seq_pc       = pc_plus4;
`endif

  assign pc_next_o = redirect_valid_i ? align_word(redirect_pc_i) : seq_pc;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, issues one memory read at a time and
// holds the returned word for decode. Optional macro: FETCH_PREDECODE_JUMP_EN.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  inst_fetch_if.master       bus,
  output fetch_state_e       state_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         discard_q, discard_d;
  logic         inst_valid_q, inst_valid_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  p_count_q, p_count_d;
  logic [31:0]  pc_next;

  fetch_pc_gen u_pc_gen (
    .pc_i             (pc_q),
    .redirect_valid_i (bus.redirect_valid),
    .redirect_pc_i    (bus.redirect_pc),
    .rdata_i          (bus.imem_rdata),
    .pc_next_o        (pc_next)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    discard_d    = discard_q;
    inst_valid_d = inst_valid_q;
    instr_d      = instr_q;
    p_count_d    = p_count_q;
    case (state_q)
      REQ: begin
        // The request leaves this cycle regardless, so a redirect here must
        // mark its eventual return as wrong-path.
        state_d = WAIT;
        if (bus.redirect_valid) begin
          pc_d      = pc_next;
          discard_d = 1'b1;
        end
      end
      WAIT: begin
        if (bus.redirect_valid) begin
          pc_d = pc_next;
          if (bus.imem_rvalid) begin
            discard_d = 1'b0;
            state_d   = REQ;
          end else begin
            discard_d = 1'b1;
          end
        end else if (bus.imem_rvalid) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = REQ;
          end else begin
            instr_d      = bus.imem_rdata;
            p_count_d    = pc_q;
            inst_valid_d = 1'b1;
            pc_d         = pc_next;
            state_d      = HOLD;
          end
        end
      end
      HOLD: begin
        if (bus.redirect_valid || bus.id_ready) begin
          inst_valid_d = 1'b0;
          instr_d      = NOP_INSTR;
          state_d      = REQ;
          if (bus.redirect_valid) pc_d = pc_next;
        end
      end
      default: state_d = REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= REQ;
      pc_q         <= RESET_PC;
      discard_q    <= 1'b0;
      inst_valid_q <= 1'b0;
      instr_q      <= NOP_INSTR;
      p_count_q    <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      discard_q    <= discard_d;
      inst_valid_q <= inst_valid_d;
      instr_q      <= instr_d;
      p_count_q    <= p_count_d;
    end
  end

  // Request strobe is the REQ state itself, suppressed while reset is held.
  assign bus.imem_req    = (state_q == REQ) && !reset;
  assign bus.imem_addr   = bus.imem_req ? pc_q : 32'h0;
  assign bus.inst_valid  = inst_valid_q;
  assign bus.instruction = instr_q;
  assign bus.p_count     = p_count_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed sequences, a table of redirect/fetch
// vectors, then random traffic against a transaction-level fetch model.
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic         clk = 1'b0;
  logic         reset;
  fetch_state_e dbg_state;

  inst_fetch_if bus ();

  inst_fetch #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .state_o (dbg_state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int consumed = 0;

  // memory responder
  logic        drv_reset;
  logic        mem_busy;
  int          mem_cnt;
  int          mem_lat;
  logic [31:0] mem_data;
  logic        dir_word_en;
  logic [31:0] dir_word;
  logic        inject_rvalid;
  logic [31:0] inject_data;

  // fetch model: next expected address, one outstanding read, held queue
  logic        sb_en;
  logic [31:0] exp_pc;
  logic        outstanding;
  logic        stale;
  logic [31:0] out_addr;
  logic        req_exp_next;
  logic [63:0] exp_q[$];

  typedef struct {
    logic [31:0] tgt;
    logic [31:0] word;
    logic [31:0] exp_pc;
    logic [31:0] exp_next;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_next(input logic [31:0] addr, input logic [31:0] word);
    logic [31:0] p4;
    p4 = addr + 32'd4;
`ifdef FETCH_PREDECODE_JUMP_EN
    if (word[31:26] == 6'h02 || word[31:26] == 6'h03) return {p4[31:28], word[25:0], 2'b00};
`else
    if (word == 32'hFFFF_FFFF) return p4;
`endif
    return p4;
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 3) == 0) w[31:26] = ($urandom_range(0, 1) == 1) ? 6'h03 : 6'h02;
    return w;
  endfunction

  task automatic sb_reset();
    exp_q.delete();
    exp_pc       = RST_PC;
    outstanding  = 1'b0;
    stale        = 1'b0;
    out_addr     = 32'h0;
    req_exp_next = 1'b1;
  endtask

  task automatic monitor();
    logic [63:0] front;
    logic        live;
    live = bus.imem_req || outstanding || (exp_q.size() != 0);
    chk("liveness", {31'd0, live}, 32'd1);
    if (req_exp_next) begin
      chk("req_after_release", {31'd0, bus.imem_req}, 32'd1);
      req_exp_next = 1'b0;
    end
    if (bus.imem_req) begin
      chk("req_addr", bus.imem_addr, exp_pc);
      chk("req_single_outstanding", {31'd0, outstanding}, 32'd0);
      outstanding = 1'b1;
      stale       = 1'b0;
      out_addr    = bus.imem_addr;
    end
    chk("inst_valid", {31'd0, bus.inst_valid}, {31'd0, (exp_q.size() != 0)});
    if (exp_q.size() != 0) begin
      front = exp_q[0];
      chk("p_count", bus.p_count, front[63:32]);
      chk("instruction", bus.instruction, front[31:0]);
      if (bus.redirect_valid || bus.id_ready) begin
        void'(exp_q.pop_front());
        req_exp_next = 1'b1;
        if (!bus.redirect_valid) consumed++;
      end
    end else begin
      chk("instruction_nop", bus.instruction, NOP);
    end
    if (bus.imem_rvalid) begin
      chk("rvalid_in_wait", {31'd0, outstanding}, 32'd1);
      if (!bus.redirect_valid && !stale && outstanding) begin
        exp_q.push_back({out_addr, bus.imem_rdata});
        exp_pc = model_next(out_addr, bus.imem_rdata);
      end else begin
        req_exp_next = 1'b1;
      end
      outstanding = 1'b0;
      stale       = 1'b0;
    end
    if (bus.redirect_valid) begin
      exp_pc = {bus.redirect_pc[31:2], 2'b00};
      if (outstanding) stale = 1'b1;
    end
  endtask

  // One clock: drive inputs just after the rising edge, observe at the falling edge.
  task automatic step(input logic redir, input logic [31:0] tgt, input logic rdy);
    @(posedge clk);
    #1;
    reset           = drv_reset;
    bus.imem_rvalid = 1'b0;
    if (drv_reset) begin
      mem_busy = 1'b0;
    end else if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt <= 0) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem_data;
        mem_busy        = 1'b0;
      end
    end
    if (inject_rvalid) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = inject_data;
      inject_rvalid   = 1'b0;
    end
    bus.redirect_valid = redir;
    bus.redirect_pc    = tgt;
    bus.id_ready       = rdy;
    @(negedge clk);
    if (!reset && sb_en) monitor();
    if (!reset && bus.imem_req) begin
      mem_busy = 1'b1;
      mem_cnt  = (mem_lat == 0) ? int'($urandom_range(1, 4)) : mem_lat;
      mem_data = dir_word_en ? dir_word : rand_word();
    end
  endtask

  task automatic do_reset();
    drv_reset = 1'b1;
    repeat (3) step(1'b0, 32'h0, 1'b0);
    chk("rst_imem_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_imem_addr", bus.imem_addr, 32'h0);
    chk("rst_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("rst_instruction", bus.instruction, NOP);
    chk("rst_p_count", bus.p_count, 32'h0);
    chk("rst_state", {30'd0, dbg_state}, {30'd0, REQ});
    drv_reset = 1'b0;
    sb_reset();
  endtask

  task automatic wait_req(input string name);
    int n;
    n = 0;
    while (!bus.imem_req && n < 12) begin
      step(1'b0, 32'h0, 1'b0);
      n++;
    end
    if (!bus.imem_req) begin
      checks++;
      errors++;
      $display("FAIL %s: no imem_req within 12 cycles", name);
    end
  endtask

  initial begin
    int  n;
    logic valid_seen;

    vecs[0] = '{32'h0000_0103, 32'h1111_1111, 32'h0000_0100, 32'h0000_0104};
    vecs[1] = '{32'hFFFF_FFFC, 32'h2222_2222, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0000};
`ifdef FETCH_PREDECODE_JUMP_EN
    vecs[3] = '{32'h0040_0000, 32'h0800_0010, 32'h0040_0000, 32'h0000_0040};
    vecs[4] = '{32'h1234_5670, 32'h0C00_0001, 32'h1234_5670, 32'h1000_0004};
    vecs[5] = '{32'hF000_0008, 32'h0BFF_FFFF, 32'hF000_0008, 32'hFFFF_FFFC};
`else
    vecs[3] = '{32'h0040_0000, 32'h0800_0010, 32'h0040_0000, 32'h0040_0004};
    vecs[4] = '{32'h1234_5670, 32'h0C00_0001, 32'h1234_5670, 32'h1234_5674};
    vecs[5] = '{32'hF000_0008, 32'h0BFF_FFFF, 32'hF000_0008, 32'hF000_000C};
`endif

    reset              = 1'b1;
    drv_reset          = 1'b1;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = 32'h0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.id_ready       = 1'b0;
    mem_busy           = 1'b0;
    mem_cnt            = 0;
    mem_data           = 32'h0;
    inject_rvalid      = 1'b0;
    inject_data        = 32'h0;
    sb_en              = 1'b1;
    sb_reset();

    // Reset, then a 1-cycle memory returning 0x2002_0005
    mem_lat     = 1;
    dir_word_en = 1'b1;
    dir_word    = 32'h2002_0005;
    do_reset();
    step(1'b0, 32'h0, 1'b0);
    chk("d1_req", {31'd0, bus.imem_req}, 32'd1);
    chk("d1_addr", bus.imem_addr, 32'h0);
    step(1'b0, 32'h0, 1'b0);
    chk("d1_wait_valid", {31'd0, bus.inst_valid}, 32'd0);
    step(1'b0, 32'h0, 1'b0);
    chk("d1_valid", {31'd0, bus.inst_valid}, 32'd1);
    chk("d1_p_count", bus.p_count, 32'h0);
    chk("d1_instr", bus.instruction, 32'h2002_0005);

    // Decode stalls for 5 cycles
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 32'h0, 1'b0);
      chk("d2_valid", {31'd0, bus.inst_valid}, 32'd1);
      chk("d2_no_req", {31'd0, bus.imem_req}, 32'd0);
      chk("d2_instr", bus.instruction, 32'h2002_0005);
      chk("d2_p_count", bus.p_count, 32'h0);
    end
    step(1'b0, 32'h0, 1'b1);
    mem_lat = 4;
    step(1'b0, 32'h0, 1'b0);
    chk("d1_next_req", {31'd0, bus.imem_req}, 32'd1);
    chk("d1_next_addr", bus.imem_addr, 32'h4);

    // Redirect to 0x103 during a 4-cycle WAIT
    mem_lat = 2;
    step(1'b1, 32'h0000_0103, 1'b0);
    n = 0;
    valid_seen = 1'b0;
    do begin
      step(1'b0, 32'h0, 1'b0);
      n++;
      if (bus.inst_valid) valid_seen = 1'b1;
    end while (!bus.imem_req && n < 12);
    chk("d3_cycles_to_req", n, 32'd4);
    chk("d3_no_valid", {31'd0, valid_seen}, 32'd0);
    chk("d3_addr", bus.imem_addr, 32'h0000_0100);

    // Redirect coincident with imem_rvalid
    step(1'b0, 32'h0, 1'b0);
    mem_lat = 1;
    step(1'b1, 32'h0000_0200, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    chk("d4a_req", {31'd0, bus.imem_req}, 32'd1);
    chk("d4a_addr", bus.imem_addr, 32'h0000_0200);
    chk("d4a_valid", {31'd0, bus.inst_valid}, 32'd0);

    // Redirect coincident with id_ready in HOLD
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    chk("d4b_hold_valid", {31'd0, bus.inst_valid}, 32'd1);
    step(1'b1, 32'h0000_0300, 1'b1);
    step(1'b0, 32'h0, 1'b0);
    chk("d4b_req", {31'd0, bus.imem_req}, 32'd1);
    chk("d4b_addr", bus.imem_addr, 32'h0000_0300);
    chk("d4b_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("d4b_instr", bus.instruction, NOP);

    // Table: redirect to target, fetch, deliver, check following fetch address
    for (int i = 0; i < 6; i++) begin
      mem_lat  = 1;
      dir_word = vecs[i].word;
      step(1'b1, vecs[i].tgt, 1'b0);
      step(1'b0, 32'h0, 1'b0);
      wait_req("tbl_fetch_req");
      chk("tbl_fetch_addr", bus.imem_addr, vecs[i].exp_pc);
      step(1'b0, 32'h0, 1'b0);
      step(1'b0, 32'h0, 1'b0);
      chk("tbl_valid", {31'd0, bus.inst_valid}, 32'd1);
      chk("tbl_p_count", bus.p_count, vecs[i].exp_pc);
      chk("tbl_instr", bus.instruction, vecs[i].word);
      step(1'b0, 32'h0, 1'b1);
      step(1'b0, 32'h0, 1'b0);
      chk("tbl_next_req", {31'd0, bus.imem_req}, 32'd1);
      chk("tbl_next_addr", bus.imem_addr, vecs[i].exp_next);
    end

    // Reset in the middle of WAIT, then a late imem_rvalid in REQ
    mem_lat = 3;
    step(1'b1, 32'h0000_0500, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    wait_req("rl_pre_req");
    step(1'b0, 32'h0, 1'b0);
    sb_en     = 1'b0;
    drv_reset = 1'b1;
    step(1'b0, 32'h0, 1'b0);
    drv_reset     = 1'b0;
    inject_rvalid = 1'b1;
    inject_data   = 32'hDEAD_BEEF;
    dir_word      = 32'h3333_3333;
    step(1'b0, 32'h0, 1'b0);
    chk("rl_req", {31'd0, bus.imem_req}, 32'd1);
    chk("rl_addr", bus.imem_addr, RST_PC);
    step(1'b0, 32'h0, 1'b0);
    chk("rl_state", {30'd0, dbg_state}, {30'd0, WAIT});
    chk("rl_valid", {31'd0, bus.inst_valid}, 32'd0);
    n = 0;
    while (!bus.inst_valid && n < 10) begin
      step(1'b0, 32'h0, 1'b0);
      n++;
    end
    chk("rl_deliver_instr", bus.instruction, 32'h3333_3333);
    chk("rl_deliver_p_count", bus.p_count, RST_PC);
    do_reset();
    sb_en = 1'b1;

    // Random traffic against the fetch model
    consumed    = 0;
    mem_lat     = 0;
    dir_word_en = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      logic        r;
      logic [31:0] t;
      r = ($urandom_range(0, 99) < 7);
      t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      step(r, t, ($urandom_range(0, 2) != 0));
    end
    chk("random_progress", {31'd0, (consumed > 200)}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
